// File: rtl/mcst_mii_pkg.sv
// Shared MII burst-generator constants: state encoding, PRBS9 seed/taps, preamble/SFD nibbles.
package mcst_mii_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // Taps at bits 8 and 4 give x^9 + x^5 + 1 with the newest bit shifted in at bit 0.
  localparam logic [8:0] PRBS9_SEED = 9'h1FF;
  localparam logic [8:0] PRBS9_TAPS = 9'h110;

  localparam nibble_t NIB_PREAMBLE = 4'h5;
  localparam nibble_t NIB_SFD      = 4'hD;

  typedef struct packed {
    logic [8:0] state;
    nibble_t    nibble;
  } prbs9_step_t;

  // Four PRBS9 steps; the first generated bit lands in nibble bit 0.
  function automatic prbs9_step_t prbs9_step4(input logic [8:0] state);
    prbs9_step_t r;
    logic [8:0]  t;
    logic        b;
    t        = state;
    r.nibble = 4'h0;
    for (int i = 0; i < 4; i++) begin
      b        = ^(t & PRBS9_TAPS);
      r.nibble = {b, r.nibble[3:1]};
      t        = {t[7:0], b};
    end
    r.state = t;
    return r;
  endfunction

endpackage

// File: rtl/mii_burst_gen_if.sv
// MII Tx bus between the burst generator (master) and the Manchester transmitter (slave).
interface mii_burst_gen_if;
  import mcst_mii_pkg::*;

  nibble_t MiiTxData;
  logic    MiiTxEn;
  logic    MiiTxCEn;
  logic    MiiTxBusy;

  modport master (output MiiTxData, output MiiTxEn, input MiiTxCEn, input MiiTxBusy);
  modport slave  (input MiiTxData, input MiiTxEn, output MiiTxCEn, output MiiTxBusy);

endinterface

// File: rtl/prbs9_nibble_src.sv
// PRBS9 nibble source; nibble shows the next four bits, advance consumes them.
// reset is active-low and asynchronous, restoring the seed.
module prbs9_nibble_src
  import mcst_mii_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    advance,
  output nibble_t nibble
);

  logic [8:0]  state_r;
  prbs9_step_t step_s;

  assign step_s = prbs9_step4(state_r);
  assign nibble = step_s.nibble;

  // LFSR state register, seeded only by reset so bursts continue the sequence
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= PRBS9_SEED;
    end else if (advance) begin
      state_r <= step_s.state;
    end
  end

endmodule

// File: rtl/mii_burst_gen.sv
// MII burst traffic generator: optional preamble/SFD, PRBS9 data nibbles, idle gap.
// Preamble/SFD slots exist only when MII_BURST_GEN_PREAMBLE_EN is defined.
module mii_burst_gen
  import mcst_mii_pkg::*;
#(
  parameter int unsigned BurstLen = 100,
  parameter int unsigned GapLen   = 20,
  parameter int unsigned PreLen   = 16
) (
  input  logic            SysClk,
  input  logic            McstTxRst_N,
  input  logic            Enable,
  mii_burst_gen_if.master mii,
  output logic [15:0]     BurstCnt,
  output logic            BurstDone
);

  localparam logic [15:0] BURST_LAST = 16'(BurstLen - 32'd1);
  localparam logic [15:0] GAP_LAST   = 16'(GapLen - 32'd1);
`ifdef MII_BURST_GEN_PREAMBLE_EN
  localparam logic [1:0]  FIRST_STATE = ST_PRE;
  localparam logic [15:0] FIRST_LAST  = 16'(PreLen - 32'd1);
`else
  localparam logic [1:0]  FIRST_STATE = ST_DATA;
  localparam logic [15:0] FIRST_LAST  = BURST_LAST;
  logic unused_pre_s;
  assign unused_pre_s = (PreLen == 32'd0) ^ (^{ST_PRE, NIB_PREAMBLE, NIB_SFD});
`endif

  logic [1:0]  state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [15:0] burst_cnt_r;
  nibble_t     data_r, data_s, prbs_nib_s;
  logic        en_r, en_s;
  logic        done_r, last_s;
  logic        advance_s, start_s;

  assign start_s = Enable & ~mii.MiiTxBusy;

  prbs9_nibble_src u_prbs (
    .clock   (SysClk),
    .reset   (McstTxRst_N),
    .advance (advance_s),
    .nibble  (prbs_nib_s)
  );

  // State and counter for the slot loaded on the next CEn edge
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = FIRST_STATE;
          cnt_s   = FIRST_LAST;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = 16'd0;
        end
      end
`ifdef MII_BURST_GEN_PREAMBLE_EN
      ST_PRE: begin
        if (cnt_r == 16'd0) begin
          state_s = ST_DATA;
          cnt_s   = BURST_LAST;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
`endif
      ST_DATA: begin
        if (cnt_r == 16'd0) begin
          state_s = ST_GAP;
          cnt_s   = GAP_LAST;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      ST_GAP: begin
        // The last gap slot re-arms immediately so back-to-back bursts add no idle slot.
        if (cnt_r != 16'd0) begin
          cnt_s = cnt_r - 16'd1;
        end else if (start_s) begin
          state_s = FIRST_STATE;
          cnt_s   = FIRST_LAST;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = 16'd0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 16'd0;
      end
    endcase
  end

  // Line nibble for the upcoming slot
  always_comb begin
    data_s    = 4'h0;
    en_s      = 1'b0;
    last_s    = 1'b0;
    advance_s = 1'b0;
    case (state_s)
`ifdef MII_BURST_GEN_PREAMBLE_EN
      ST_PRE: begin
        en_s   = 1'b1;
        data_s = (cnt_s == 16'd0) ? NIB_SFD : NIB_PREAMBLE;
      end
`endif
      ST_DATA: begin
        en_s      = 1'b1;
        data_s    = prbs_nib_s;
        last_s    = (cnt_s == 16'd0);
        advance_s = mii.MiiTxCEn;
      end
      default: begin
        en_s   = 1'b0;
        data_s = 4'h0;
      end
    endcase
  end

  // Slot registers: everything but the done pulse moves only on CEn edges
  always_ff @(posedge SysClk or negedge McstTxRst_N) begin
    if (!McstTxRst_N) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'd0;
      data_r      <= 4'h0;
      en_r        <= 1'b0;
      done_r      <= 1'b0;
      burst_cnt_r <= 16'd0;
    end else if (mii.MiiTxCEn) begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      data_r      <= data_s;
      en_r        <= en_s;
      done_r      <= last_s;
      burst_cnt_r <= burst_cnt_r + {15'd0, last_s};
    end else begin
      done_r <= 1'b0;
    end
  end

  assign mii.MiiTxData = data_r;
  assign mii.MiiTxEn   = en_r;
  assign BurstCnt      = burst_cnt_r;
  assign BurstDone     = done_r;

endmodule
